// File: rtl/muldiv_ctrl.sv
`timescale 1ns/1ps
// muldiv_ctrl: sequences the shared multiply/divide unit and owns the architectural HI/LO registers.
// Latency: MULT/MULTU MUL_LAT cycles, DIV/DIVU 33 cycles, divide-by-zero 1 cycle, MTHI/MTLO written at accept.
// Backpressure: busy_o stalls HI/LO consumers; start_i is only taken in IDLE, so the requester must hold it.
//
// Ports: clk, reset (synchronous, active-high); start_i/op_i/src_a/src_b request from execute;
//        flush_i cancels in-flight work; busy_o operation in flight; done_o commit pulse;
//        hi_rd/lo_rd architectural HI/LO.
// Build option HILO_FWD_EN: hi_rd/lo_rd bypass the value being written this cycle, and done_o
//        rises in the final busy cycle instead of the cycle after.
module muldiv_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_rd,
    output logic [31:0] lo_rd
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [4:0] MUL_LOAD = 5'(MUL_LAT - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, SIGN} state_t;
    state_t state, stateNext;

    logic [4:0]  cnt;
    logic [63:0] prod;
    logic [31:0] divisor, rem, quo;
    logic        negQ, negR, divZero;
    logic [31:0] hiReg, loReg;

    logic        accept, finish, commit, isSigned;
    logic [63:0] prodNext;
    logic [31:0] magA, magB, quoFinal, remFinal;
    logic [32:0] remShift, trial;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        accept   = (state == IDLE) && start_i && !flush_i;
        // finish marks the last busy cycle; a flush in that cycle wins over the commit
        finish   = !flush_i && (((state == MUL) && (cnt == 5'd0)) || (state == SIGN));
        commit   = finish && !((state == SIGN) && divZero);
        isSigned = (op_i == OP_MULT) || (op_i == OP_DIV);
        // sign- or zero-extend to 64 bits so one unsigned multiply covers both flavours
        prodNext = {{32{isSigned & src_a[31]}}, src_a} * {{32{isSigned & src_b[31]}}, src_b};
        magA     = (isSigned && src_a[31]) ? 32'd0 - src_a : src_a;
        magB     = (isSigned && src_b[31]) ? 32'd0 - src_b : src_b;
        // restoring step: shift next dividend bit into the partial remainder, trial-subtract
        remShift = {rem, quo[31]};
        trial    = remShift - {1'b0, divisor};
        quoFinal = negQ ? 32'd0 - quo : quo;
        remFinal = negR ? 32'd0 - rem : rem;
        busy_o   = (state != IDLE);

        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op_i)
                        OP_MULT, OP_MULTU: stateNext = MUL;
                        OP_DIV, OP_DIVU:   stateNext = (src_b == 32'd0) ? SIGN : DIV;
                        default:           stateNext = IDLE;
                    endcase
                end
            end
            MUL:     if (flush_i || (cnt == 5'd0)) stateNext = IDLE;
            DIV: begin
                if (flush_i)               stateNext = IDLE;
                else if (cnt == 5'd0)      stateNext = SIGN;
            end
            SIGN:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 5'd0;
            prod    <= 64'd0;
            divisor <= 32'd0;
            rem     <= 32'd0;
            quo     <= 32'd0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            divZero <= 1'b0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op_i)
                            OP_MULT, OP_MULTU: begin
                                prod <= prodNext;
                                cnt  <= MUL_LOAD;
                            end
                            OP_DIV, OP_DIVU: begin
                                divisor <= magB;
                                quo     <= magA;
                                rem     <= 32'd0;
                                negQ    <= isSigned & (src_a[31] ^ src_b[31]);
                                negR    <= isSigned & src_a[31];
                                divZero <= (src_b == 32'd0);
                                cnt     <= 5'd31;
                            end
                            OP_MTHI: hiReg <= src_a;
                            OP_MTLO: loReg <= src_a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                    if (commit) {hiReg, loReg} <= prod;
                end
                DIV: begin
                    if (!trial[32]) begin
                        rem <= trial[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= remShift[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                SIGN: begin
                    if (commit) begin
                        hiReg <= remFinal;
                        loReg <= quoFinal;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HILO_FWD_EN
    always_comb begin
        done_o = finish && !reset;
        hi_rd  = hiReg;
        lo_rd  = loReg;
        if (!reset) begin
            if (accept && (op_i == OP_MTHI)) hi_rd = src_a;
            if (accept && (op_i == OP_MTLO)) lo_rd = src_a;
            if (commit && (state == MUL)) begin
                hi_rd = prod[63:32];
                lo_rd = prod[31:0];
            end
            if (commit && (state == SIGN)) begin
                hi_rd = remFinal;
                lo_rd = quoFinal;
            end
        end
    end
`else
    logic doneReg;

    // done follows the commit edge, so it is seen while the FSM is already back in IDLE
    always_ff @(posedge clk) begin
        if (reset) doneReg <= 1'b0;
        else       doneReg <= finish;
    end

    assign done_o = doneReg;
    assign hi_rd  = hiReg;
    assign lo_rd  = loReg;
`endif

endmodule
